// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// gray2bin is only referenced when GRAY_INPUT_EN is defined.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Each binary bit is the XOR of all Gray bits at or above it.
  // Zero-extended upper bits leave the low bits of the result unaffected.
  function automatic logic [63:0] gray2bin(input logic [63:0] g);
    logic [63:0] b;
    b = g;
    for (int i = 1; i < 64; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/module_bcd_digit_adj.sv
// Combinational double-dabble digit correction: add 3 when the digit is 5 or more.
module module_bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // 4-bit wrap is intentional: a valid digit never exceeds 9, so 9+3 fits.
  assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? digit_i + BCD_ADJ_ADD : digit_i;

endmodule

// File: rtl/module_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one word per transaction.
// Define GRAY_INPUT_EN to treat in_data as Gray code, decoded at capture.
module module_bcd_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  bcd_state_t       state_q,   state_d;
  logic [WIDTH-1:0] bin_q,     bin_d;
  logic [BCD_W-1:0] bcd_q,     bcd_d;
  logic             ovf_q,     ovf_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [BCD_W-1:0] out_bcd_q, out_bcd_d;
  logic             out_ovf_q, out_ovf_d;

  logic [BCD_W-1:0] bcd_adj;
  logic [WIDTH-1:0] capture_val;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    module_bcd_digit_adj u_adj (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

`ifdef GRAY_INPUT_EN
  assign capture_val = WIDTH'(gray2bin(64'(in_data)));
`else
  assign capture_val = in_data;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    out_bcd_d = out_bcd_q;
    out_ovf_d = out_ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bin_d   = capture_val;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The bit shifted out of the top digit can only be 1 if the value no longer fits.
        {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
        ovf_d          = ovf_q | bcd_adj[BCD_W-1];
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          out_bcd_d = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
          out_ovf_d = ovf_q | bcd_adj[BCD_W-1];
          state_d   = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      out_bcd_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      out_bcd_q <= out_bcd_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_bcd = out_bcd_q;
  assign out_ovf = out_ovf_q;

endmodule
